// File: rtl/conv_layer_axi_lite_slave.sv
// AXI4-Lite register front end for the convolution core: start pulse, sticky
// done/err status with write-1-to-clear, level interrupt and six config words.
module conv_layer_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_NUM_REGS         = 8
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              core_busy,
  input  logic                              core_done,
  input  logic                              core_err,
  output logic                              start_pulse,
  output logic [6*C_S_AXI_DATA_WIDTH-1:0]   cfg_regs,
  output logic                              irq
);

  localparam int DW      = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W   = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NUM_CFG = 6;
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // VALID and READY are both high; a VALID source holds its payload until then.
  logic            aw_ready_q, aw_ready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            ar_ready_q, ar_ready_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            start_q, start_d;
  logic            irq_en_q, irq_en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            irq_q, irq_d;
  logic [DW-1:0]   cfg_q [NUM_CFG];
  logic [DW-1:0]   cfg_d [NUM_CFG];

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_ok, rd_ok, wr_hs, rd_hs;
  logic [DW-1:0]    rd_word;
  logic             unused_ok;

  assign wr_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_ok  = int'(wr_idx) < C_NUM_REGS;
  assign rd_ok  = int'(rd_idx) < C_NUM_REGS;
  assign wr_hs  = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs  = ar_ready_q & S_AXI_ARVALID;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Read mux works on current register state, so a same-edge write is not seen.
  always_comb begin
    rd_word = '0;
    if (rd_idx == IDX_CTRL) begin
      rd_word = {{(DW-2){1'b0}}, irq_en_q, 1'b0};
    end else if (rd_idx == IDX_STATUS) begin
      rd_word = {{(DW-3){1'b0}}, err_q, done_q, core_busy};
    end else begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (rd_idx == IDX_W'(i + 2)) rd_word = cfg_q[i];
      end
    end
    if (!rd_ok) rd_word = '0;
  end

  always_comb begin
    aw_ready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~aw_ready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ar_ready_d = S_AXI_ARVALID & ~rvalid_q & ~ar_ready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    err_d      = err_q;
    cfg_d      = cfg_q;
    start_d    = wr_hs & (wr_idx == IDX_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
    irq_d      = irq_en_q & (done_q | err_q);

    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    if (wr_hs && wr_idx == IDX_CTRL && S_AXI_WSTRB[0]) irq_en_d = S_AXI_WDATA[1];
    if (wr_hs && wr_idx == IDX_STATUS && S_AXI_WSTRB[0]) begin
      if (S_AXI_WDATA[1]) done_d = 1'b0;
      if (S_AXI_WDATA[2]) err_d  = 1'b0;
    end
    // Core events are applied after the clear so a coincident set wins.
    if (core_done) done_d = 1'b1;
    if (core_err)  err_d  = 1'b1;

    for (int i = 0; i < NUM_CFG; i++) begin
      if (wr_hs && wr_idx == IDX_W'(i + 2)) begin
        for (int b = 0; b < DW/8; b++) begin
          if (S_AXI_WSTRB[b]) cfg_d[i][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      start_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
    end else begin
      aw_ready_q <= aw_ready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      ar_ready_q <= ar_ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      start_q    <= start_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= cfg_d[i];
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int i = 0; i < NUM_CFG; i++) cfg_regs[i*DW +: DW] = cfg_q[i];
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign start_pulse   = start_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_conv_layer_axi_lite_slave.sv
// Bench for conv_layer_axi_lite_slave: table vectors, hand-written corner
// sequences and random traffic checked against a register-map model.
module tb_conv_layer_axi_lite_slave;

  localparam int TIMEOUT = 50;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [5:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [5:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic         core_busy = 1'b0;
  logic         core_done = 1'b0;
  logic         core_err = 1'b0;
  logic         start_pulse;
  logic [191:0] cfg_regs;
  logic         irq;

  int checks = 0;
  int failures = 0;
  int start_total = 0;

  conv_layer_axi_lite_slave dut (
    .S_AXI_ACLK(aclk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .core_busy(core_busy), .core_done(core_done), .core_err(core_err),
    .start_pulse(start_pulse), .cfg_regs(cfg_regs), .irq(irq)
  );

  // Clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (act=running exp=done)");
    $fatal(1, "watchdog");
  end

  always @(negedge aclk) if (start_pulse === 1'b1) start_total <= start_total + 1;

  // Reference model of the register map
  logic [31:0] m_cfg [6];
  logic        m_irq_en, m_done, m_err;

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) m_cfg[i] = '0;
    m_irq_en = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [5:0] a);
    int idx;
    idx = int'(a[5:2]);
    return (idx >= 8) ? 2'b10 : 2'b00;
  endfunction

  function automatic void model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    logic [31:0] mask;
    idx  = int'(a[5:2]);
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (idx == 0) begin
      if (s[0]) m_irq_en = d[1];
    end else if (idx == 1) begin
      if (s[0] && d[1]) m_done = 1'b0;
      if (s[0] && d[2]) m_err = 1'b0;
    end else if (idx < 8) begin
      m_cfg[idx-2] = (m_cfg[idx-2] & ~mask) | (d & mask);
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a, input logic busy);
    int idx;
    idx = int'(a[5:2]);
    if (idx >= 8) return 32'h0;
    if (idx == 0) return {30'h0, m_irq_en, 1'b0};
    if (idx == 1) return {29'h0, m_err, m_done, busy};
    return m_cfg[idx-2];
  endfunction

  // Scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic check_cfg_model(input string name);
    for (int i = 0; i < 6; i++) check(name, cfg_regs[i*32 +: 32], m_cfg[i]);
  endtask

  // Drivers (inputs driven and outputs sampled on the falling edge)
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit done_at_hs, input bit hold_b, output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (awready !== 1'b1 && n < TIMEOUT);
    check("aw_handshake_seen", {31'h0, awready}, 32'h1);
    if (awready !== 1'b1) begin awvalid = 1'b0; wvalid = 1'b0; return; end
    check("wready_with_awready", {31'h0, wready}, 32'h1);
    if (done_at_hs) core_done = 1'b1;
    @(negedge aclk);
    core_done = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    if (hold_b) return;
    n = 0;
    while (bvalid !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
    check("bvalid_seen", {31'h0, bvalid}, 32'h1);
    if (bvalid !== 1'b1) return;
    resp = bresp; bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] data, output logic [1:0] resp);
    int n;
    data = 'x; resp = 2'bxx;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (arready !== 1'b1 && n < TIMEOUT);
    check("ar_handshake_seen", {31'h0, arready}, 32'h1);
    if (arready !== 1'b1) begin arvalid = 1'b0; return; end
    @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
    check("rvalid_seen", {31'h0, rvalid}, 32'h1);
    if (rvalid !== 1'b1) return;
    data = rdata; resp = rresp; rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          s0;

    vecs.push_back(vec_t'{1'b1, 6'h08, 32'hDEAD0011, 4'hF, 2'b00, 32'h0});
    vecs.push_back(vec_t'{1'b0, 6'h08, 32'h0,        4'h0, 2'b00, 32'hDEAD0011});
    vecs.push_back(vec_t'{1'b1, 6'h0C, 32'hABCD0001, 4'hF, 2'b00, 32'h0});
    vecs.push_back(vec_t'{1'b1, 6'h0C, 32'hBEEF0011, 4'h3, 2'b00, 32'h0});
    vecs.push_back(vec_t'{1'b0, 6'h0C, 32'h0,        4'h0, 2'b00, 32'hABCD0011});
    vecs.push_back(vec_t'{1'b0, 6'h20, 32'h0,        4'h0, 2'b10, 32'h0});
    vecs.push_back(vec_t'{1'b1, 6'h3C, 32'h12345678, 4'hF, 2'b10, 32'h0});
    vecs.push_back(vec_t'{1'b0, 6'h08, 32'h0,        4'h0, 2'b00, 32'hDEAD0011});
    vecs.push_back(vec_t'{1'b1, 6'h1C, 32'hA5A5A5A5, 4'h8, 2'b00, 32'h0});
    vecs.push_back(vec_t'{1'b0, 6'h1C, 32'h0,        4'h0, 2'b00, 32'hA5000000});
    vecs.push_back(vec_t'{1'b0, 6'h04, 32'h0,        4'h0, 2'b00, 32'h0});
    vecs.push_back(vec_t'{1'b1, 6'h02, 32'h00000002, 4'h1, 2'b00, 32'h0});
    vecs.push_back(vec_t'{1'b0, 6'h00, 32'h0,        4'h0, 2'b00, 32'h00000002});
    vecs.push_back(vec_t'{1'b1, 6'h00, 32'h00000000, 4'hE, 2'b00, 32'h0});
    vecs.push_back(vec_t'{1'b0, 6'h01, 32'h0,        4'h0, 2'b00, 32'h00000002});
    vecs.push_back(vec_t'{1'b1, 6'h00, 32'h00000000, 4'h1, 2'b00, 32'h0});
    vecs.push_back(vec_t'{1'b0, 6'h00, 32'h0,        4'h0, 2'b00, 32'h0});

    // Reset
    model_reset();
    repeat (3) @(negedge aclk);
    check("reset_handshakes", {25'h0, awready, wready, bvalid, arready, rvalid, start_pulse, irq}, 32'h0);
    check("reset_resps", {28'h0, bresp, rresp}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_cfg_model("reset_cfg");

    // Table vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, 1'b0, resp);
        check($sformatf("vec%0d_bresp", i), {30'h0, resp}, {30'h0, vecs[i].exp_resp});
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        if (i == 0) check("vec0_cfg0_port", cfg_regs[31:0], 32'hDEAD0011);
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        check($sformatf("vec%0d_rresp", i), {30'h0, resp}, {30'h0, vecs[i].exp_resp});
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      end
    end
    check_cfg_model("table_cfg");

    // Address arrives 5 cycles before data
    @(negedge aclk);
    awaddr = 6'h10; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("aw_early_no_ready", {30'h0, awready, wready}, 32'h0);
    end
    wvalid = 1'b1;
    @(negedge aclk);
    check("aw_early_ready_pair", {30'h0, awready, wready}, 32'h3);
    check("aw_early_no_bvalid_yet", {31'h0, bvalid}, 32'h0);
    @(negedge aclk);
    check("aw_early_ready_one_cycle", {30'h0, awready, wready}, 32'h0);
    check("aw_early_bvalid", {31'h0, bvalid}, 32'h1);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    model_write(6'h10, 32'h0BADF00D, 4'hF);
    axi_read(6'h10, rd, resp);
    check("aw_early_readback", rd, 32'h0BADF00D);

    // Start pulse, sticky status, irq and W1C
    s0 = start_total;
    axi_write(6'h00, 32'h3, 4'h1, 1'b0, 1'b0, resp);
    model_write(6'h00, 32'h3, 4'h1);
    repeat (2) @(negedge aclk);
    check("start_pulse_once", start_total - s0, 32'd1);
    s0 = start_total;
    axi_write(6'h00, 32'h2, 4'h1, 1'b0, 1'b0, resp);
    repeat (2) @(negedge aclk);
    check("start_pulse_none", start_total - s0, 32'd0);
    core_done = 1'b1; @(negedge aclk); core_done = 1'b0; m_done = 1'b1;
    repeat (2) @(negedge aclk);
    check("irq_after_done", {31'h0, irq}, 32'h1);
    axi_read(6'h04, rd, resp);
    check("status_done", rd, 32'h2);
    axi_write(6'h04, 32'h2, 4'h1, 1'b0, 1'b0, resp);
    model_write(6'h04, 32'h2, 4'h1);
    @(negedge aclk);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    axi_read(6'h04, rd, resp);
    check("status_cleared", rd, 32'h0);
    core_done = 1'b1; @(negedge aclk); core_done = 1'b0; m_done = 1'b1;
    axi_write(6'h04, 32'h2, 4'h1, 1'b1, 1'b0, resp);
    model_write(6'h04, 32'h2, 4'h1); m_done = 1'b1;
    axi_read(6'h04, rd, resp);
    check("status_set_wins", rd, 32'h2);
    check("irq_set_wins", {31'h0, irq}, 32'h1);
    core_err = 1'b1; @(negedge aclk); core_err = 1'b0; m_err = 1'b1;
    core_busy = 1'b1;
    axi_read(6'h04, rd, resp);
    check("status_err_busy", rd, 32'h7);
    core_busy = 1'b0;
    axi_write(6'h04, 32'h6, 4'h1, 1'b0, 1'b0, resp);
    model_write(6'h04, 32'h6, 4'h1);
    @(negedge aclk);
    check("irq_all_cleared", {31'h0, irq}, 32'h0);

    // Simultaneous read and write of one register: read sees the old value
    @(negedge aclk);
    awaddr = 6'h08; wdata = 32'hCAFE1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h08; arvalid = 1'b1;
    @(negedge aclk);
    check("simul_readies", {30'h0, awready, arready}, 32'h3);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("simul_valids", {30'h0, bvalid, rvalid}, 32'h3);
    check("simul_read_old", rdata, model_read(6'h08, 1'b0));
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    model_write(6'h08, 32'hCAFE1234, 4'hF);
    check("simul_cfg0_new", cfg_regs[31:0], 32'hCAFE1234);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      a = 6'($urandom_range(0, 63));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, s, 1'b0, 1'b0, resp);
        model_write(a, d, s);
        check($sformatf("rnd%0d_bresp", i), {30'h0, resp}, {30'h0, model_resp(a)});
        check_cfg_model($sformatf("rnd%0d_cfg", i));
        check($sformatf("rnd%0d_irq", i), {31'h0, irq}, {31'h0, m_irq_en & (m_done | m_err)});
      end else begin
        core_busy = 1'($urandom_range(0, 1));
        axi_read(a, rd, resp);
        check($sformatf("rnd%0d_rresp", i), {30'h0, resp}, {30'h0, model_resp(a)});
        check($sformatf("rnd%0d_rdata", i), rd, model_read(a, core_busy));
      end
    end
    core_busy = 1'b0;

    // Write response backpressure, parallel read, then reset mid-hold
    axi_write(6'h14, 32'h11223344, 4'hF, 1'b0, 1'b1, resp);
    model_write(6'h14, 32'h11223344, 4'hF);
    awaddr = 6'h18; wdata = 32'h55555555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("bp_hold", {30'h0, bvalid, awready}, 32'h2);
    end
    axi_read(6'h14, rd, resp);
    check("bp_parallel_read", rd, 32'h11223344);
    check("bp_still_held", {30'h0, bvalid, awready}, 32'h2);
    s0 = start_total;
    @(negedge aclk);
    aresetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    #1;
    check("rst_async_drop", {28'h0, bvalid, awready, arready, rvalid}, 32'h0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      a = 6'(i * 4);
      axi_read(a, rd, resp);
      check($sformatf("post_rst_word%0d", i), rd, model_read(a, 1'b0));
    end
    check_cfg_model("post_rst_cfg");
    check("post_rst_irq", {31'h0, irq}, 32'h0);
    check("post_rst_no_start", start_total - s0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
